// File: rtl/nand_cell_test_sequencer.sv
// Sweep/settle/sample controller that exercises a 2-input NAND cell and tallies mismatches.
// Optional first-failure capture ports are enabled by defining FIRST_FAIL_LOG_EN.
module nand_cell_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SW            = 4,
  parameter int EW            = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] sweeps,
  output logic          dut_a,
  output logic          dut_b,
  input  logic          dut_y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_count
`ifdef FIRST_FAIL_LOG_EN
  ,
  output logic          ff_valid,
  output logic [1:0]    ff_vec,
  output logic [SW-1:0] ff_sweep
`endif
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] ctr;
  logic [1:0]    vec;
  logic [1:0]    vec_nx;
  logic [SW-1:0] sweep;
  logic [SW-1:0] last_sweep;
  logic          accept;
  logic          last_vec;
  logic          mismatch;

  assign accept   = (state == IDLE) && start;
  assign last_vec = (vec == 2'd3) && (sweep == last_sweep);
  assign vec_nx   = vec + 2'd1;
  assign mismatch = (dut_y != ~(dut_a & dut_b));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETTLE;
      SETTLE:  if (ctr == '0) state_n = SAMPLE;
      SAMPLE:  state_n = last_vec ? DONE : SETTLE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      ctr        <= '0;
      vec        <= '0;
      sweep      <= '0;
      last_sweep <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Zero sweeps runs once, so the terminal index is clamped at 0.
            last_sweep <= (sweeps == '0) ? '0 : sweeps - 1'b1;
            vec        <= '0;
            sweep      <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            err_count  <= '0;
            pass       <= 1'b0;
            ctr        <= CW'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (ctr != '0) ctr <= ctr - 1'b1;
        end
        SAMPLE: begin
          if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
          if (!last_vec) begin
            vec   <= vec_nx;
            dut_a <= vec_nx[1];
            dut_b <= vec_nx[0];
            ctr   <= CW'(SETTLE_CYCLES);
            if (vec == 2'd3) sweep <= sweep + 1'b1;
          end
        end
        DONE: begin
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef FIRST_FAIL_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_sweep <= '0;
    end else if (accept) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_sweep <= '0;
    end else if ((state == SAMPLE) && mismatch && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_vec   <= vec;
      ff_sweep <= sweep;
    end
  end
`endif

endmodule
